// File: rtl/inv_key_schedule_seq.sv
// Reverse AES-128 key schedule: walks round keys NR..0 one step per valid/ready handshake.
// Build option INV_KEY_ZEROIZE_EN clears rk_out/rk_round whenever the FSM enters IDLE.

module sbox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX_TABLE[addr];
endmodule

// state | meaning
// IDLE  | no sequence active; waiting for start
// RUN   | presenting rk_out/rk_round, stepping back one round per handshake
module inv_key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);
    localparam logic [3:0] NR_ROUND = 4'(NR);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [127:0] prev_key;
    logic         handshake;

    assign {w0, w1, w2, w3} = rk_out;

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // SubWord(RotWord(p3)): byte order b1, b2, b3, b0
    sbox u_sbox_0 (.addr(p3[23:16]), .dout(sub_word[31:24]));
    sbox u_sbox_1 (.addr(p3[15:8]),  .dout(sub_word[23:16]));
    sbox u_sbox_2 (.addr(p3[7:0]),   .dout(sub_word[15:8]));
    sbox u_sbox_3 (.addr(p3[31:24]), .dout(sub_word[7:0]));

    always_comb begin
        rcon = 8'h00;
        case (rk_round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign p0        = w0 ^ sub_word ^ {rcon, 24'h0};
    assign prev_key  = {p0, p1, p2, p3};
    assign handshake = rk_valid & rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            rk_out   <= 128'h0;
            rk_round <= 4'd0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                rk_valid <= 1'b0;
`ifdef INV_KEY_ZEROIZE_EN
                rk_out   <= 128'h0;
                rk_round <= 4'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            rk_valid <= 1'b1;
                            rk_out   <= key_in;
                            rk_round <= NR_ROUND;
                        end
                    end
                    RUN: begin
                        if (handshake) begin
                            if (rk_round == 4'd0) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                rk_valid <= 1'b0;
                                done     <= 1'b1;
`ifdef INV_KEY_ZEROIZE_EN
                                rk_out   <= 128'h0;
                                rk_round <= 4'd0;
`endif
                            end else begin
                                rk_out   <= prev_key;
                                rk_round <= rk_round - 4'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inv_key_schedule_seq.sv
// Directed bench for inv_key_schedule_seq: FIPS-197 A.1 schedule, backpressure, abort, start-while-busy, async reset.
module tb_inv_key_schedule_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_q[$];
    logic [3:0]   exp_rnd_q[$];

    localparam logic [127:0] FIPS_KEYS [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    always #5 clk = ~clk;

    inv_key_schedule_seq #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_all();
        for (int r = 10; r >= 0; r--) begin
            exp_q.push_back(FIPS_KEYS[r]);
            exp_rnd_q.push_back(4'(r));
        end
    endtask

    task automatic flush();
        exp_q.delete();
        exp_rnd_q.delete();
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic start_seq(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Consumes keys from the DUT, comparing against the scoreboard.
    // Returns at the done cycle, or (stop_round >= 0) when that round is first presented.
    task automatic drain(input bit rand_ready, input int stop_round, input int max_cycles);
        bit           stalled  = 1'b0;
        bit           want_done = 1'b0;
        bit           finished = 1'b0;
        logic [127:0] held_key = '0;
        logic [3:0]   held_round = '0;
        logic [127:0] exp_key;
        logic [3:0]   exp_rnd;
        int           cyc = 0;
        while (!finished && cyc < max_cycles) begin
            if (want_done) begin
                check("done_pulse", done, 1);
                check("done_valid_low", rk_valid, 0);
                check("done_busy_low", busy, 0);
                check("idle_round", rk_round, 0);
`ifdef INV_KEY_ZEROIZE_EN
                check("idle_key_zeroized", rk_out, 0);
`else
                check("idle_key_held", rk_out, FIPS_KEYS[0]);
`endif
                rk_ready = 1'b0;
                finished = 1'b1;
            end else begin
                check("done_low", done, 0);
                check("valid_high", rk_valid, 1);
                check("busy_high", busy, 1);
                if (stalled) begin
                    check("stall_key_stable", rk_out, held_key);
                    check("stall_round_stable", rk_round, held_round);
                end
                if (stop_round >= 0 && int'(rk_round) == stop_round) begin
                    rk_ready = 1'b0;
                    finished = 1'b1;
                end else begin
                    rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (rk_ready) begin
                        check("scoreboard_nonempty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            exp_key = exp_q.pop_front();
                            exp_rnd = exp_rnd_q.pop_front();
                            check("round_key", rk_out, exp_key);
                            check("round_index", rk_round, exp_rnd);
                            want_done = (exp_rnd == 4'd0);
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled    = 1'b1;
                        held_key   = rk_out;
                        held_round = rk_round;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        check("drain_timeout", finished, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_valid", rk_valid, 0);
        check("reset_done", done, 0);
        check("reset_key", rk_out, 0);
        check("reset_round", rk_round, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // abort wins over start in IDLE
        start  = 1'b1;
        abort  = 1'b1;
        key_in = FIPS_KEYS[10];
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start_valid", rk_valid, 0);
        check("abort_beats_start_busy", busy, 0);

        // FIPS-197 A.1 with rk_ready held high
        push_all();
        start_seq(FIPS_KEYS[10]);
        check("first_valid_latency", rk_valid, 1);
        drain(1'b0, -1, 14);
        check("fips_scoreboard_empty", exp_q.size(), 0);

        // start in the done cycle, then run with random backpressure
        push_all();
        start_seq(FIPS_KEYS[10]);
        drain(1'b1, -1, 400);
        check("bp_scoreboard_empty", exp_q.size(), 0);

        // abort at round 6 together with rk_ready
        push_all();
        start_seq(FIPS_KEYS[10]);
        drain(1'b0, 6, 50);
        check("abort_at_round", rk_round, 6);
        abort    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        rk_ready = 1'b0;
        check("abort_valid", rk_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done_later", done, 0);
        end
        flush();

        // fresh start after abort emits round 10 again
        push_all();
        start_seq(FIPS_KEYS[10]);
        check("restart_round", rk_round, 10);
        drain(1'b0, -1, 14);

        // start while busy is ignored
        push_all();
        start_seq(FIPS_KEYS[10]);
        drain(1'b1, 5, 200);
        start    = 1'b1;
        key_in   = '1;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_round", rk_round, 5);
        check("busy_start_key", rk_out, FIPS_KEYS[5]);
        drain(1'b1, -1, 200);

        // asynchronous reset mid-sequence
        push_all();
        start_seq(FIPS_KEYS[10]);
        drain(1'b0, 7, 50);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_valid", rk_valid, 0);
        check("areset_done", done, 0);
        check("areset_key", rk_out, 0);
        check("areset_round", rk_round, 0);
        flush();
        rk_ready = 1'b1;
        @(negedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_valid", rk_valid, 0);
            check("post_reset_busy", busy, 0);
        end
        rk_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inv_key_schedule_seq.md
Name: inv_key_schedule_seq

Overview:
- Sequential reverse AES-128 key scheduler for the decryption datapath.
- Accepts the last round key (round NR) and walks the schedule backwards, one round per handshake.
- Streams round keys NR, NR-1, ..., 0 over a valid/ready interface; round 0 is the original cipher key.
- Counterpart of the forward single-round expansion block; reuses the existing SBox module (addr/dout), four instances.

Parameters:
- NR, 10, number of the first round emitted; legal range 1..10. Rcon entry used when stepping from round r to r-1 is RC[r].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- abort  input  1  cancel the current sequence
- key_in  input  128  round-NR key, words w0..w3 MSB-first, same packing as the forward block
- busy  output  1  high while in RUN
- rk_valid  output  1  rk_out/rk_round hold a valid key
- rk_ready  input  1  consumer accepts the current key
- rk_out  output  128  current round key
- rk_round  output  4  round index of rk_out
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, rk_valid=0, done=0, rk_out=0, rk_round=0.
- FSM has two states: IDLE and RUN.
- IDLE -> RUN: start=1 and abort=0.
  - Next cycle: rk_out=key_in, rk_round=NR, rk_valid=1, busy=1.
  - Start-to-first-valid latency is 1 cycle.
- RUN, handshake (rk_valid & rk_ready) with rk_round>0:
  - Next cycle: rk_out=prev(rk_out, RC[rk_round]) and rk_round decrements.
  - rk_valid stays high, so back-to-back handshakes give 1 key per cycle.
- RUN, handshake with rk_round==0:
  - Next cycle: IDLE, rk_valid=0, busy=0, done=1 for one cycle.
- RUN, no handshake: rk_out and rk_round hold stable (AXI-style; valid never drops without a handshake or abort).
- Inverse step, with w0..w3 the current words:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0.
  - w0' = w0 ^ ({S(b1),S(b2),S(b3),S(b0)} ^ {RC[r],24'h0}), where b0..b3 are the bytes of w3', MSB-first.
- RC[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The next-key computation is combinational from rk_out; the result is registered on handshake only.
- abort:
  - Any state: next cycle IDLE, rk_valid=0, busy=0, no done pulse.
  - abort beats start and beats a simultaneous handshake.
- start while busy is ignored.
- start in the same cycle done is asserted is accepted, since the FSM is already IDLE.
- rst_n deasserted mid-sequence: immediate return to reset values; no partial output afterwards.

Optional Feature:
- Macro: INV_KEY_ZEROIZE_EN
- Defined:
  - rk_out is cleared to 128'h0 and rk_round to 0 on the cycle the FSM enters IDLE, whether by completion or abort.
  - No key material remains on the bus when idle.
- Undefined: rk_out and rk_round hold their last values in IDLE. This saves the clear mux.
- rk_valid behaviour is identical in both builds.

Test Plan:
- FIPS-197 A.1, rk_ready=1:
  - Stimulus: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse.
  - Response: the 11 keys arrive on consecutive cycles.
  - Round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses one cycle after round 0 is accepted.
- Backpressure:
  - Stimulus: same key, rk_ready toggled pseudo-randomly.
  - Response: rk_out/rk_round stable while rk_ready=0; identical key sequence; no key skipped or repeated.
- Abort:
  - Stimulus: abort asserted while rk_round=6, together with rk_ready=1.
  - Response: next cycle rk_valid=0, busy=0, done never pulses.
  - A fresh start then emits round 10 again.
- Start while busy:
  - Stimulus: start pulsed with key_in=all-ones during round 5.
  - Response: ignored; the sequence continues with the original key.
- Async reset:
  - Stimulus: rst_n=0 mid-sequence, not clock-aligned.
  - Response: all outputs 0 immediately; rk_valid stays 0 after release until the next start.
- Zeroize (INV_KEY_ZEROIZE_EN defined vs undefined):
  - Defined: after done, rk_out=0.
  - Undefined: rk_out=2b7e151628aed2a6abf7158809cf4f3c.
